// File: rtl/cond_control_unit_if.sv
// Decode-side bus of cond_control_unit: instruction fields and status write-back in,
// pipelined control word and architectural NZCV out.
interface cond_control_unit_if #(
    parameter int ALU_CMD_W = 4
);
    // valid_in marks a real instruction. There is no ready: while stall is high the unit
    // ignores the input, so the producer must keep the same instruction on the bus until
    // stall drops. flush kills everything in flight and also drops that cycle's input.
    logic                 valid_in;
    logic                 stall;
    logic                 flush;
    logic [1:0]           mode;
    logic [3:0]           op_code;
    logic                 s;
    logic [3:0]           cond;
    logic                 status_wr_en;
    logic [3:0]           status_nzcv_in;

    logic                 valid_out;
    logic                 wb_en;
    logic                 mem_read;
    logic                 mem_write;
    logic [ALU_CMD_W-1:0] alu_cmd;
    logic                 b;
    logic                 s_out;
    logic                 undef;
    logic [3:0]           status_q;

    modport master (
        output valid_in, stall, flush, mode, op_code, s, cond, status_wr_en, status_nzcv_in,
        input  valid_out, wb_en, mem_read, mem_write, alu_cmd, b, s_out, undef, status_q
    );

    modport slave (
        input  valid_in, stall, flush, mode, op_code, s, cond, status_wr_en, status_nzcv_in,
        output valid_out, wb_en, mem_read, mem_write, alu_cmd, b, s_out, undef, status_q
    );
endinterface

// File: rtl/cond_control_unit.sv
// ARM-style decode control unit: opcode decode, condition check against the owned NZCV
// register, and a PIPE_STAGES-deep output pipeline with stall and flush.
module cond_control_unit #(
    parameter int PIPE_STAGES = 1,
    parameter int ALU_CMD_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    cond_control_unit_if.slave bus
);

    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic                 mem_read;
        logic                 mem_write;
        logic [ALU_CMD_W-1:0] alu_cmd;
        logic                 b;
        logic                 s_out;
        logic                 undef;
    } entry_t;

    logic [3:0] status_r;
    logic [3:0] flags;
    logic       cond_pass;
    logic       legal;
    logic [3:0] cmd4;
    entry_t     dec;
    entry_t     entry_d;
    entry_t     pipe [PIPE_STAGES];

    // Same-cycle EX write-back is bypassed so a flag-setting op followed directly
    // by a conditional one sees the new flags.
    assign flags = bus.status_wr_en ? bus.status_nzcv_in : status_r;

    always_comb begin
        cond_pass = 1'b0;
        case (bus.cond)
            4'h0: cond_pass = flags[2];
            4'h1: cond_pass = !flags[2];
            4'h2: cond_pass = flags[1];
            4'h3: cond_pass = !flags[1];
            4'h4: cond_pass = flags[3];
            4'h5: cond_pass = !flags[3];
            4'h6: cond_pass = flags[0];
            4'h7: cond_pass = !flags[0];
            4'h8: cond_pass = flags[1] && !flags[2];
            4'h9: cond_pass = !flags[1] || flags[2];
            4'ha: cond_pass = (flags[3] == flags[0]);
            4'hb: cond_pass = (flags[3] != flags[0]);
            4'hc: cond_pass = !flags[2] && (flags[3] == flags[0]);
            4'hd: cond_pass = flags[2] || (flags[3] != flags[0]);
            4'he: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        dec       = '0;
        cmd4      = 4'd0;
        legal     = 1'b1;
        dec.valid = 1'b1;
        dec.wb_en = 1'b1;
        case ({bus.mode, bus.op_code})
            6'b001101: cmd4 = 4'b0001;
            6'b001111: cmd4 = 4'b1001;
            6'b000100: cmd4 = 4'b0010;
            6'b000101: cmd4 = 4'b0011;
            6'b000010: cmd4 = 4'b0100;
            6'b000110: cmd4 = 4'b0101;
            6'b000000: cmd4 = 4'b0110;
            6'b001100: cmd4 = 4'b0111;
            6'b000001: cmd4 = 4'b1000;
            6'b001010: begin
                cmd4      = 4'b0100;
                dec.wb_en = 1'b0;
            end
            6'b001000: begin
                cmd4      = 4'b0110;
                dec.wb_en = 1'b0;
            end
            6'b010100: begin
                cmd4          = 4'b0010;
                dec.mem_read  = bus.s;
                dec.mem_write = !bus.s;
                dec.wb_en     = bus.s;
            end
            default: begin
                if (bus.mode == 2'b10) begin
                    dec.wb_en = 1'b0;
                    dec.b     = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
        endcase
        dec.alu_cmd = ALU_CMD_W'(cmd4);
        dec.s_out   = (bus.mode == 2'b00) && bus.s;
    end

    // A failed condition still occupies a slot as a valid bubble; undef only for executed ops.
    always_comb begin
        entry_d = '0;
        if (bus.valid_in) begin
            if (!cond_pass) begin
                entry_d.valid = 1'b1;
            end else if (!legal) begin
                entry_d.valid = 1'b1;
                entry_d.undef = 1'b1;
            end else begin
                entry_d = dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_STAGES; k++) pipe[k] <= '0;
        end else if (bus.flush) begin
            for (int k = 0; k < PIPE_STAGES; k++) pipe[k] <= '0;
        end else if (!bus.stall) begin
            pipe[0] <= entry_d;
            for (int k = 1; k < PIPE_STAGES; k++) pipe[k] <= pipe[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_r <= 4'b0000;
        end else if (bus.status_wr_en) begin
            status_r <= bus.status_nzcv_in;
        end
    end

    assign bus.valid_out = pipe[PIPE_STAGES-1].valid;
    assign bus.wb_en     = pipe[PIPE_STAGES-1].wb_en;
    assign bus.mem_read  = pipe[PIPE_STAGES-1].mem_read;
    assign bus.mem_write = pipe[PIPE_STAGES-1].mem_write;
    assign bus.alu_cmd   = pipe[PIPE_STAGES-1].alu_cmd;
    assign bus.b         = pipe[PIPE_STAGES-1].b;
    assign bus.s_out     = pipe[PIPE_STAGES-1].s_out;
    assign bus.undef     = pipe[PIPE_STAGES-1].undef;
    assign bus.status_q  = status_r;

endmodule

// File: tb/tb_cond_control_unit.sv
// Bench for cond_control_unit: three instances (depth 1, 2, 3; the last with a 6-bit
// alu_cmd) share stimulus and are checked against a queue-based reference model.
module tb_cond_control_unit;

  localparam int EW = 13;  // {valid, wb, mr, mw, alu[5:0], b, s_out, undef}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cond_control_unit_if #(.ALU_CMD_W(4)) if1 ();
  cond_control_unit_if #(.ALU_CMD_W(4)) if2 ();
  cond_control_unit_if #(.ALU_CMD_W(6)) if3 ();

  cond_control_unit #(.PIPE_STAGES(1), .ALU_CMD_W(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  cond_control_unit #(.PIPE_STAGES(2), .ALU_CMD_W(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  cond_control_unit #(.PIPE_STAGES(3), .ALU_CMD_W(6)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int n_tests = 0;
  int n_fail = 0;

  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];
  logic [EW-1:0] exp_q3[$];
  logic [3:0]    exp_status;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: ARM condition = base test on cond[3:1], inverted by cond[0] (AL/NV special).
  function automatic logic [EW-1:0] model_entry(input logic vin, input logic [1:0] md,
      input logic [3:0] op, input logic sb, input logic [3:0] cd, input logic [3:0] f);
    logic n, z, c, v, base, pass, wb, mr, mw, br, so;
    logic [5:0] alu;
    if (!vin) return '0;
    {n, z, c, v} = f;
    case (cd[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cd == 4'hf) pass = 1'b0;
    else if (cd == 4'he) pass = 1'b1;
    else pass = base ^ cd[0];
    if (!pass) return {1'b1, 12'b0};
    wb = 1'b1; mr = 1'b0; mw = 1'b0; br = 1'b0; so = 1'b0; alu = 6'd0;
    if (md == 2'b10) begin
      br = 1'b1; wb = 1'b0;
    end else if (md == 2'b01 && op == 4'b0100) begin
      alu = 6'd2; mr = sb; mw = !sb; wb = sb;
    end else if (md == 2'b00) begin
      so = sb;
      case (op)
        4'b1101: alu = 6'd1;
        4'b1111: alu = 6'd9;
        4'b0100: alu = 6'd2;
        4'b0101: alu = 6'd3;
        4'b0010: alu = 6'd4;
        4'b0110: alu = 6'd5;
        4'b0000: alu = 6'd6;
        4'b1100: alu = 6'd7;
        4'b0001: alu = 6'd8;
        4'b1010: begin alu = 6'd4; wb = 1'b0; end
        4'b1000: begin alu = 6'd6; wb = 1'b0; end
        default: return {1'b1, 11'b0, 1'b1};
      endcase
    end else begin
      return {1'b1, 11'b0, 1'b1};
    end
    return {1'b1, wb, mr, mw, alu, br, so, 1'b0};
  endfunction

  function automatic logic [EW-1:0] pack(input logic v, input logic wb, input logic mr,
      input logic mw, input logic [5:0] a, input logic br, input logic so, input logic un);
    return {v, wb, mr, mw, a, br, so, un};
  endfunction

  task automatic reset_model();
    exp_q1.delete(); exp_q2.delete(); exp_q3.delete();
    repeat (1) exp_q1.push_back('0);
    repeat (2) exp_q2.push_back('0);
    repeat (3) exp_q3.push_back('0);
    exp_status = 4'b0000;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_p1"}, 32'(pack(if1.valid_out, if1.wb_en, if1.mem_read, if1.mem_write,
          6'(if1.alu_cmd), if1.b, if1.s_out, if1.undef)), 32'(exp_q1[$]));
    check({tag, "_p2"}, 32'(pack(if2.valid_out, if2.wb_en, if2.mem_read, if2.mem_write,
          6'(if2.alu_cmd), if2.b, if2.s_out, if2.undef)), 32'(exp_q2[$]));
    check({tag, "_p3"}, 32'(pack(if3.valid_out, if3.wb_en, if3.mem_read, if3.mem_write,
          if3.alu_cmd, if3.b, if3.s_out, if3.undef)), 32'(exp_q3[$]));
    check({tag, "_status"}, {20'd0, if1.status_q, if2.status_q, if3.status_q},
          {20'd0, exp_status, exp_status, exp_status});
  endtask

  task automatic drive(input logic vin, input logic st, input logic fl, input logic [1:0] md,
      input logic [3:0] op, input logic sb, input logic [3:0] cd, input logic swe,
      input logic [3:0] snz);
    if1.valid_in = vin; if1.stall = st; if1.flush = fl; if1.mode = md; if1.op_code = op;
    if1.s = sb; if1.cond = cd; if1.status_wr_en = swe; if1.status_nzcv_in = snz;
    if2.valid_in = vin; if2.stall = st; if2.flush = fl; if2.mode = md; if2.op_code = op;
    if2.s = sb; if2.cond = cd; if2.status_wr_en = swe; if2.status_nzcv_in = snz;
    if3.valid_in = vin; if3.stall = st; if3.flush = fl; if3.mode = md; if3.op_code = op;
    if3.s = sb; if3.cond = cd; if3.status_wr_en = swe; if3.status_nzcv_in = snz;
  endtask

  // One clock: drive, advance the model at the edge, then compare 1 time unit later.
  task automatic cycle(input string tag, input logic vin, input logic st, input logic fl,
      input logic [1:0] md, input logic [3:0] op, input logic sb, input logic [3:0] cd,
      input logic swe, input logic [3:0] snz);
    logic [EW-1:0] e;
    drive(vin, st, fl, md, op, sb, cd, swe, snz);
    e = model_entry(vin, md, op, sb, cd, swe ? snz : exp_status);
    @(posedge clk);
    if (fl) begin
      foreach (exp_q1[i]) exp_q1[i] = '0;
      foreach (exp_q2[i]) exp_q2[i] = '0;
      foreach (exp_q3[i]) exp_q3[i] = '0;
    end else if (!st) begin
      exp_q1.push_front(e); void'(exp_q1.pop_back());
      exp_q2.push_front(e); void'(exp_q2.pop_back());
      exp_q3.push_front(e); void'(exp_q3.pop_back());
    end
    if (swe) exp_status = snz;
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 4'he, 1'b0, 4'h0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 4'he, 1'b0, 4'h0);
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD, always: depth-3 output appears after the third edge
    cycle("add", 1'b1, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b1, 4'he, 1'b0, 4'h0);
    idle("add_w1");
    idle("add_w2");
    check("add_p3_valid", 32'(if3.valid_out), 32'd1);
    check("add_p3_alu", 32'(if3.alu_cmd), 32'd2);
    check("add_p3_wb_s", {30'd0, if3.wb_en, if3.s_out}, 32'd3);

    // Z set: STR NE is a bubble, STR EQ executes
    cycle("setz", 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 4'he, 1'b1, 4'b0100);
    cycle("str_ne", 1'b1, 1'b0, 1'b0, 2'b01, 4'b0100, 1'b0, 4'h1, 1'b0, 4'h0);
    check("str_ne_bubble", 32'(pack(if1.valid_out, if1.wb_en, if1.mem_read, if1.mem_write,
          6'(if1.alu_cmd), if1.b, if1.s_out, if1.undef)), 32'h1000);
    cycle("str_eq", 1'b1, 1'b0, 1'b0, 2'b01, 4'b0100, 1'b0, 4'h0, 1'b0, 4'h0);
    check("str_eq_ctrl", {27'd0, if1.mem_write, if1.wb_en, 6'(if1.alu_cmd) == 6'd2}, 32'b101);

    // Bypass of same-cycle status write
    cycle("clr", 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 4'he, 1'b1, 4'b0000);
    cycle("mov_byp", 1'b1, 1'b0, 1'b0, 2'b00, 4'b1101, 1'b0, 4'h0, 1'b1, 4'b0100);
    check("mov_byp_alu", 32'(if1.alu_cmd), 32'd1);
    check("mov_byp_wb", 32'(if1.wb_en), 32'd1);
    check("mov_byp_status", 32'(if1.status_q), 32'h4);

    // Stall with LDR at depth-2 output, then stall+flush with a status write
    cycle("ldr", 1'b1, 1'b0, 1'b0, 2'b01, 4'b0100, 1'b1, 4'he, 1'b0, 4'h0);
    idle("ldr_w");
    for (int i = 0; i < 3; i++) begin
      cycle("stall", 1'b1, 1'b1, 1'b0, 2'b00, 4'b1101, 1'b0, 4'he, 1'b0, 4'h0);
      check("stall_p2_ldr", {30'd0, if2.valid_out, if2.mem_read}, 32'b11);
    end
    cycle("stall_flush", 1'b1, 1'b1, 1'b1, 2'b00, 4'b1101, 1'b0, 4'he, 1'b1, 4'b1001);
    check("flush_p2_valid", 32'(if2.valid_out), 32'd0);
    check("flush_status", 32'(if2.status_q), 32'h9);

    // Undefined encoding: undef only when the condition passes
    cycle("undef_al", 1'b1, 1'b0, 1'b0, 2'b00, 4'b1001, 1'b0, 4'he, 1'b0, 4'h0);
    check("undef_al", 32'(pack(if1.valid_out, if1.wb_en, if1.mem_read, if1.mem_write,
          6'(if1.alu_cmd), if1.b, if1.s_out, if1.undef)), 32'h1001);
    cycle("undef_nv", 1'b1, 1'b0, 1'b0, 2'b00, 4'b1001, 1'b0, 4'hf, 1'b0, 4'h0);
    check("undef_nv", {30'd0, if1.valid_out, if1.undef}, 32'b10);

    // Random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst_n = 1'b0;
        #2;
        reset_model();
        compare_all("async_rst");
        rst_n = 1'b1;
      end
      cycle("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
